// File: rtl/neo_prot_bank_if.sv
// 68K port-space / loader / P2 bus bundle for neo_prot_bank.
// master = the 68K decode + ROM loader side, slave = the protection unit.
interface neo_prot_bank_if #(
  parameter int ADDR_W = 24
);
  logic              ENABLE;
  logic [19:1]       M68K_ADDR;
  logic [15:0]       M68K_DATA_IN;
  logic [15:0]       PROM_DATA;
  logic              nPORTOEL;
  logic              nPORTOEU;
  logic              nPORTWEL;
  logic              nPORTWEU;
  logic              CFG_WE;
  logic [7:0]        CFG_ADDR;
  logic [31:0]       CFG_DATA;
  logic [15:0]       M68K_DATA_OUT;
  logic              DATA_OE_L;
  logic              DATA_OE_U;
  logic [ADDR_W-1:0] P2_ADDR;
  logic              BUSY;

  modport master (
    output ENABLE, M68K_ADDR, M68K_DATA_IN, PROM_DATA,
           nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU,
           CFG_WE, CFG_ADDR, CFG_DATA,
    input  M68K_DATA_OUT, DATA_OE_L, DATA_OE_U, P2_ADDR, BUSY
  );

  modport slave (
    input  ENABLE, M68K_ADDR, M68K_DATA_IN, PROM_DATA,
           nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU,
           CFG_WE, CFG_ADDR, CFG_DATA,
    output M68K_DATA_OUT, DATA_OE_L, DATA_OE_U, P2_ADDR, BUSY
  );
endinterface

// File: rtl/neo_prot_bank.sv
// neo_prot_bank: loader-configurable P-ROM protection / banking unit.
// Bank table, index bit permutation and register addresses come from the
// ROM loader over CFG_*. A bank write runs IDLE -> LOOKUP -> COMMIT; the
// new bank shows on P2_ADDR once COMMIT retires. Includes an LFSR RNG and
// an ID word on the read path.
// Optional: define NEO_PROT_BANK_READBACK_EN to make BANK_ADDR reads return
// the last committed table index.
module neo_prot_bank #(
  parameter int              NUM_ENTRIES = 64,
  parameter int              IDX_W       = 6,
  parameter int              ADDR_W      = 24,
  parameter int              LFSR_W      = 16,
  parameter logic [15:0]     LFSR_SEED   = 16'h2345,
  parameter logic [15:0]     LFSR_TAPS   = 16'h98EC,
  parameter logic [15:0]     ID_VALUE    = 16'h9A37
) (
  input  logic               CLK_48M,
  input  logic               nRESET,
  neo_prot_bank_if.slave     bus
);

  localparam logic [7:0] A_BANK = 8'hF0;
  localparam logic [7:0] A_RNG1 = 8'hF1;
  localparam logic [7:0] A_RNG2 = 8'hF2;
  localparam logic [7:0] A_ID   = 8'hF3;
  localparam logic [7:0] A_SEL  = 8'hF4;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMMIT} state_t;

  // loader-owned state, survives reset
  logic [ADDR_W-1:0]  table_mem [NUM_ENTRIES];
  logic [18:0]        bank_addr, rng_addr1, rng_addr2, id_addr;
  logic [4*IDX_W-1:0] idx_sel;

  // runtime state
  state_t             state;
  logic               busy;
  logic [ADDR_W-1:0]  bank;
  logic [ADDR_W-1:0]  rd_data;
  logic [IDX_W-1:0]   idx_q;
  logic [LFSR_W-1:0]  rng;
  logic               seeded;
  logic               we_q, oe_q;

  logic               port_we, port_oe, we_fall, oe_fall;
  logic               cfg_is_tbl;
  logic [IDX_W-1:0]   idx_new;
  logic               fb;
  logic [15:0]        rng_ext;
  logic [ADDR_W-1:0]  word_addr;
  logic [15:0]        data_out;
  logic               unused_cfg;

  assign port_we    = bus.nPORTWEL & bus.nPORTWEU;
  assign port_oe    = bus.nPORTOEL & bus.nPORTOEU;
  assign we_fall    = ~port_we & we_q;
  assign oe_fall    = ~port_oe & oe_q;
  assign cfg_is_tbl = ({1'b0, bus.CFG_ADDR} < 9'(NUM_ENTRIES));
  assign fb         = ^(rng & LFSR_TAPS[LFSR_W-1:0]);
  assign unused_cfg = ^bus.CFG_DATA[31:ADDR_W];

  // each index bit is picked from the write data by its 4-bit selector field
  for (genvar i = 0; i < IDX_W; i++) begin : g_idx
    assign idx_new[i] = bus.M68K_DATA_IN[idx_sel[4*i +: 4]];
  end

`ifdef NEO_PROT_BANK_READBACK_EN
  logic [IDX_W-1:0] last_idx;
  logic [15:0]      idx_ext;

  // last committed index, kept only for debug readback
  always_ff @(posedge CLK_48M) begin
    if (!nRESET)                last_idx <= '0;
    else if (state == S_COMMIT) last_idx <= idx_q;
  end

  // zero-extend the stored index onto the data bus
  always_comb begin
    idx_ext             = '0;
    idx_ext[IDX_W-1:0]  = last_idx;
  end
`endif

  // loader writes: table entries and config registers, never reset
  always_ff @(posedge CLK_48M) begin
    if (bus.CFG_WE) begin
      if (cfg_is_tbl) table_mem[bus.CFG_ADDR[IDX_W-1:0]] <= bus.CFG_DATA[ADDR_W-1:0];
      case (bus.CFG_ADDR)
        A_BANK:  bank_addr <= bus.CFG_DATA[18:0];
        A_RNG1:  rng_addr1 <= bus.CFG_DATA[18:0];
        A_RNG2:  rng_addr2 <= bus.CFG_DATA[18:0];
        A_ID:    id_addr   <= bus.CFG_DATA[18:0];
        A_SEL:   idx_sel   <= bus.CFG_DATA[4*IDX_W-1:0];
        default: ;
      endcase
    end
  end

  // strobe edge detect and RNG; first read after reset only seeds
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      we_q   <= 1'b1;
      oe_q   <= 1'b1;
      rng    <= '0;
      seeded <= 1'b0;
    end else begin
      we_q <= port_we;
      oe_q <= port_oe;
      if (oe_fall && bus.ENABLE) begin
        if (!seeded) begin
          rng    <= LFSR_SEED[LFSR_W-1:0];
          seeded <= 1'b1;
        end else begin
          rng <= {rng[LFSR_W-2:0], fb};
        end
      end
    end
  end

  // bank FSM; table read is read-first so a same-cycle loader write is not seen
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      bank  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (we_fall && bus.ENABLE && (bus.M68K_ADDR == bank_addr)) begin
            idx_q <= idx_new;
            state <= S_LOOKUP;
            busy  <= 1'b1;
          end
        end
        S_LOOKUP: begin
          rd_data <= table_mem[idx_q];
          state   <= S_COMMIT;
        end
        S_COMMIT: begin
          bank  <= rd_data;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // banked P2 address, wraps modulo 2^ADDR_W
  always_comb begin
    word_addr       = '0;
    word_addr[19:0] = {bus.M68K_ADDR, 1'b0};
  end

  // zero-extend the RNG onto the data bus
  always_comb begin
    rng_ext             = '0;
    rng_ext[LFSR_W-1:0] = rng;
  end

  // read data priority: ID, (bank readback), RNG, P-ROM
  always_comb begin
    data_out = '0;
    if (bus.ENABLE) begin
      if (bus.M68K_ADDR == id_addr)
        data_out = ID_VALUE;
`ifdef NEO_PROT_BANK_READBACK_EN
      else if (bus.M68K_ADDR == bank_addr)
        data_out = idx_ext;
`endif
      else if ((bus.M68K_ADDR == rng_addr1) || (bus.M68K_ADDR == rng_addr2))
        data_out = rng_ext;
      else
        data_out = bus.PROM_DATA;
    end
  end

  assign bus.M68K_DATA_OUT = data_out;
  assign bus.DATA_OE_L     = ~bus.nPORTOEL & bus.ENABLE;
  assign bus.DATA_OE_U     = ~bus.nPORTOEU & bus.ENABLE;
  assign bus.P2_ADDR       = bus.ENABLE ? (bank + word_addr) : '0;
  assign bus.BUSY          = busy;

endmodule

// File: tb/tb_neo_prot_bank.sv
// Directed bench for neo_prot_bank: bank lookup timing, busy-drop, read-first
// table, index permutation, RNG sequence, ID/OE, reset abort, wrap, disable.
module tb_neo_prot_bank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  neo_prot_bank_if bus ();

  neo_prot_bank dut (
    .CLK_48M (clk),
    .nRESET  (rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.CFG_WE   = 1'b1;
    bus.CFG_ADDR = a;
    bus.CFG_DATA = d;
    @(negedge clk);
    bus.CFG_WE   = 1'b0;
  endtask

  // one read pulse with both byte strobes; checks the data seen during it
  task automatic rd_chk(input string tag, input logic [18:0] a, input logic [15:0] exp);
    @(negedge clk);
    bus.M68K_ADDR = a;
    bus.nPORTOEL  = 1'b0;
    bus.nPORTOEU  = 1'b0;
    #1 chk(tag, 32'(bus.M68K_DATA_OUT), 32'(exp));
    @(negedge clk);
    bus.nPORTOEL  = 1'b1;
    bus.nPORTOEU  = 1'b1;
  endtask

  // one-cycle write pulse; returns at the negedge after the detecting edge
  task automatic bank_wr(input logic [18:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.M68K_ADDR    = a;
    bus.M68K_DATA_IN = d;
    bus.nPORTWEL     = 1'b0;
    bus.nPORTWEU     = 1'b0;
    @(negedge clk);
    bus.nPORTWEL     = 1'b1;
    bus.nPORTWEU     = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ENABLE       = 1'b1;
    bus.M68K_ADDR    = '0;
    bus.M68K_DATA_IN = '0;
    bus.PROM_DATA    = 16'hBEEF;
    bus.nPORTOEL     = 1'b1;
    bus.nPORTOEU     = 1'b1;
    bus.nPORTWEL     = 1'b1;
    bus.nPORTWEU     = 1'b1;
    bus.CFG_WE       = 1'b0;
    bus.CFG_ADDR     = '0;
    bus.CFG_DATA     = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_p2",   32'(bus.P2_ADDR), 32'h0);
    rst_n = 1'b1;

    cfg(8'hF4, 32'h0054_3210);
    cfg(8'hF0, 32'h0007_FFF8);
    cfg(8'hF1, 32'h0007_FFFC);
    cfg(8'hF2, 32'h0007_FFFD);
    cfg(8'hF3, 32'h0007_F223);
    cfg(8'h05, 32'h003C_C000);
    cfg(8'h06, 32'h0011_1000);
    cfg(8'h02, 32'h00FF_F000);

    // RNG: first read seeds, then shifts in XOR(rng & taps)
    rd_chk("rng_0",    19'h7FFFC, 16'h0000);
    rd_chk("rng_1",    19'h7FFFC, 16'h2345);
    rd_chk("rng_2",    19'h7FFFC, 16'h468A);
    rd_chk("rng_3",    19'h7FFFC, 16'h8D14);
    rd_chk("rng_addr2", 19'h7FFFD, 16'h1A29);

    // ID word and byte enables
    @(negedge clk);
    bus.M68K_ADDR = 19'h7F223;
    bus.nPORTOEL  = 1'b0;
    bus.nPORTOEU  = 1'b0;
    #1;
    chk("id_data", 32'(bus.M68K_DATA_OUT), 32'h9A37);
    chk("id_oe_l", 32'(bus.DATA_OE_L), 32'h1);
    chk("id_oe_u", 32'(bus.DATA_OE_U), 32'h1);
    @(negedge clk);
    bus.nPORTOEL = 1'b1;
    bus.nPORTOEU = 1'b1;
    @(negedge clk);
    bus.nPORTOEL = 1'b0;
    #1;
    chk("lo_oe_l", 32'(bus.DATA_OE_L), 32'h1);
    chk("lo_oe_u", 32'(bus.DATA_OE_U), 32'h0);
    @(negedge clk);
    bus.nPORTOEL = 1'b1;

    rd_chk("prom", 19'h00100, 16'hBEEF);

    // bank lookup: busy in cycles 1-2, new bank in cycle 3
    bank_wr(19'h7FFF8, 16'h0005);
    bus.M68K_ADDR = 19'h00010;
    #1;
    chk("c1_busy", 32'(bus.BUSY), 32'h1);
    chk("c1_p2",   32'(bus.P2_ADDR), 32'h000020);
    @(negedge clk);
    #1;
    chk("c2_busy", 32'(bus.BUSY), 32'h1);
    chk("c2_p2",   32'(bus.P2_ADDR), 32'h000020);
    @(negedge clk);
    #1;
    chk("c3_busy", 32'(bus.BUSY), 32'h0);
    chk("c3_p2",   32'(bus.P2_ADDR), 32'h3CC020);

    // lookup of 6 with a same-entry table write during LOOKUP, plus a second
    // bank write (index 2) while busy that must be dropped
    bank_wr(19'h7FFF8, 16'h0006);
    bus.CFG_WE   = 1'b1;
    bus.CFG_ADDR = 8'h06;
    bus.CFG_DATA = 32'h0022_2000;
    @(negedge clk);
    bus.CFG_WE       = 1'b0;
    bus.M68K_DATA_IN = 16'h0002;
    bus.nPORTWEL     = 1'b0;
    bus.nPORTWEU     = 1'b0;
    @(negedge clk);
    bus.nPORTWEL  = 1'b1;
    bus.nPORTWEU  = 1'b1;
    bus.M68K_ADDR = 19'h00010;
    repeat (3) @(negedge clk);
    #1;
    chk("busy_drop_busy", 32'(bus.BUSY), 32'h0);
    chk("read_first_p2",  32'(bus.P2_ADDR), 32'h111020);

    bank_wr(19'h7FFF8, 16'h0006);
    bus.M68K_ADDR = 19'h00010;
    repeat (2) @(negedge clk);
    #1 chk("tbl_new_p2", 32'(bus.P2_ADDR), 32'h222020);

    // permuted index: bit i <- data bit i+8, so 0x0500 selects entry 5
    cfg(8'hF4, 32'h00DC_BA98);
    bank_wr(19'h7FFF8, 16'h0500);
    bus.M68K_ADDR = 19'h00010;
    repeat (2) @(negedge clk);
    #1 chk("perm_p2", 32'(bus.P2_ADDR), 32'h3CC020);
    cfg(8'hF4, 32'h0054_3210);

    // reset during LOOKUP aborts; bank is 0 and RNG restarts unseeded
    bank_wr(19'h7FFF8, 16'h0002);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.M68K_ADDR = 19'h00010;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_p2",   32'(bus.P2_ADDR), 32'h000020);
    chk("abort_busy", 32'(bus.BUSY), 32'h0);
    rd_chk("abort_rng0", 19'h7FFFC, 16'h0000);
    rd_chk("abort_rng1", 19'h7FFFC, 16'h2345);

    // wrap: 0xFFF000 + 0xFFFFE
    bank_wr(19'h7FFF8, 16'h0002);
    repeat (2) @(negedge clk);
    bus.M68K_ADDR = 19'h7FFFF;
    #1 chk("wrap_p2", 32'(bus.P2_ADDR), 32'h0FEFFE);

`ifdef NEO_PROT_BANK_READBACK_EN
    rd_chk("bank_rd", 19'h7FFF8, 16'h0002);
`else
    rd_chk("bank_rd", 19'h7FFF8, 16'hBEEF);
`endif

    // disabled: no address, no drive, no data
    @(negedge clk);
    bus.ENABLE    = 1'b0;
    bus.M68K_ADDR = 19'h7F223;
    bus.nPORTOEL  = 1'b0;
    bus.nPORTOEU  = 1'b0;
    #1;
    chk("dis_p2",   32'(bus.P2_ADDR), 32'h0);
    chk("dis_oe_l", 32'(bus.DATA_OE_L), 32'h0);
    chk("dis_oe_u", 32'(bus.DATA_OE_U), 32'h0);
    chk("dis_data", 32'(bus.M68K_DATA_OUT), 32'h0);
    @(negedge clk);
    bus.nPORTOEL = 1'b1;
    bus.nPORTOEU = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/neo_prot_bank.md
Name: neo_prot_bank

Overview:
- Runtime-configurable successor to the per-game NEO-SMA style P-ROM protection/banking unit.
- The bank table, the index bit-permutation and the register addresses are loaded from the ROM loader, not hard-coded per game.
- Sits between the 68K port-space decode and the P2 SDRAM address path.
- Produces the banked P2 address, the ID/RNG read data, and an LFSR-based RNG of parametrised width and taps.

Parameters:
- NUM_ENTRIES, 64, bank table depth; power of two.
- IDX_W, 6, table index width = log2(NUM_ENTRIES).
- ADDR_W, 24, P2 address and table entry width.
- LFSR_W, 16, RNG width; 16 or 8 supported.
- LFSR_SEED, 16'h2345, value loaded on the first read edge after reset.
- LFSR_TAPS, 16'h98EC, feedback mask: feedback = XOR-reduce(rng & LFSR_TAPS).
- ID_VALUE, 16'h9A37, word returned at ID_ADDR.

Ports:
- CLK_48M  in  1  system clock.
- nRESET  in  1  synchronous active-low reset, sampled on CLK_48M rising edge.
- ENABLE  in  1  protection active for the loaded cart.
- M68K_ADDR  in  19  68K word address [19:1].
- M68K_DATA_IN  in  16  68K write data.
- PROM_DATA  in  16  P-ROM read data, pass-through.
- nPORTOEL, nPORTOEU  in  1 each  port read strobes.
- nPORTWEL, nPORTWEU  in  1 each  port write strobes.
- CFG_WE  in  1  loader config/table write strobe, one cycle per word.
- CFG_ADDR  in  8  0..NUM_ENTRIES-1 = table entry; 0xF0 = BANK_ADDR; 0xF1 = RNG_ADDR1; 0xF2 = RNG_ADDR2; 0xF3 = ID_ADDR; 0xF4 = IDX_SEL.
- CFG_DATA  in  ADDR_W+?  write data, 32 bits; low bits used.
- M68K_DATA_OUT  out  16  read data.
- DATA_OE_L, DATA_OE_U  out  1 each  drive enables for the low/high data bytes.
- P2_ADDR  out  ADDR_W  banked P2 address.
- BUSY  out  1  a bank lookup is in flight.

Behaviour:
- Reset (nRESET low at a clock edge):
  - bank = 0, rng = 0, seeded flag = 0, FSM = IDLE, BUSY = 0.
  - Edge-detect registers set to 1.
  - Config registers and table contents are NOT cleared.
- Edge detection:
  - nPORTWE = nPORTWEL & nPORTWEU; nPORTOE = nPORTOEL & nPORTOEU.
  - Each is registered once; a falling edge is strobe low while the registered copy is high.
- Index formation:
  - IDX_SEL holds IDX_W 4-bit fields.
  - Index bit i = M68K_DATA_IN[IDX_SEL field i], captured at the write edge.
- Bank FSM:
  - IDLE: on a write falling edge with ENABLE=1 and M68K_ADDR==BANK_ADDR, capture the index -> LOOKUP, BUSY=1.
  - LOOKUP: the synchronous table read completes (1-cycle RAM) -> COMMIT.
  - COMMIT: bank <= table data -> IDLE, BUSY=0.
  - Latency: the new bank is visible on P2_ADDR 3 cycles after the clock edge that sees the falling edge.
  - Write edges arriving while BUSY=1 are ignored.
- Table load:
  - CFG_WE with CFG_ADDR < NUM_ENTRIES writes that entry; accepted in any FSM state.
  - A same-entry write during LOOKUP returns the old data (read-first).
  - Config writes to 0xF0–0xF4 take effect on the next cycle.
- P2_ADDR:
  - ENABLE=1: bank + {M68K_ADDR,1'b0}, modulo 2^ADDR_W (wrap, no saturation), combinational.
  - ENABLE=0: 0.
- Read data, when ENABLE=1, by priority:
  1. M68K_ADDR==ID_ADDR -> ID_VALUE.
  2. RNG_ADDR1 or RNG_ADDR2 -> rng, zero-extended to 16 bits.
  3. Otherwise -> PROM_DATA.
  - DATA_OE_L = ~nPORTOEL & ENABLE; DATA_OE_U = ~nPORTOEU & ENABLE.
  - ENABLE=0: both OEs low, M68K_DATA_OUT = 0.
- RNG:
  - Advances on every port-read falling edge (any address) when ENABLE=1.
  - If seeded=0: rng <= LFSR_SEED[LFSR_W-1:0] and seeded <= 1.
  - Otherwise: rng <= {rng[LFSR_W-2:0], feedback}.
  - The read that causes the edge returns the pre-update value.
- Simultaneous events:
  - A read edge and a write edge on the same cycle are both processed.
  - Reset asserted mid-LOOKUP/COMMIT aborts the FSM; bank stays 0.
  - ENABLE dropping mid-lookup: the FSM completes, but P2_ADDR stays 0 while ENABLE=0.

Optional Feature:
- Macro: NEO_PROT_BANK_READBACK_EN.
- Defined: a read of BANK_ADDR (below ID, above RNG in priority) returns {IDX_W-bit last committed index, zero-extended}, for debug/homebrew carts.
- Undefined: BANK_ADDR reads return PROM_DATA; the index is not stored.

Test Plan:
- Identity IDX_SEL (0x543210), table[5]=0x3CC000, BANK_ADDR=0x7FFF8, write 0x0005 to 0x7FFF8, then M68K_ADDR=0x00010 -> P2_ADDR=0x3CC020 exactly 3 cycles after the edge; BUSY high for cycles 1–2.
- RNG_ADDR1=0x7FFFC; after reset, three reads -> 0x0000, then 0x2345, then 0x468A (feedback bit 0 = 0 under taps 0x98EC).
- Read at ID_ADDR=0x7F223 with both OEs low -> 0x9A37, DATA_OE_L=DATA_OE_U=1; read with only nPORTOEL low -> DATA_OE_U=0.
- Second bank write 1 cycle after the first -> ignored; bank equals the first entry; table write to the same index during LOOKUP -> old value committed.
- nRESET low during LOOKUP -> P2_ADDR = {M68K_ADDR,0}; the next read returns rng 0x0000 and then seeds.
- bank=0xFFF000, M68K_ADDR=0x7FFFF -> P2_ADDR=0x0FEFFE (wrap); ENABLE=0 -> P2_ADDR=0, OEs low.
